branch_target_buffer: RTL

Direct-mapped branch target buffer (BTB) in the IF stage, directly upstream of the ID-stage bimodal direction predictor. It supplies a predicted target for the fetch PC as soon as the PC is known, so fetch can redirect before decode. Entries are allocated and refreshed from branch resolution in the MEM stage. A sequential sweep clears all valid bits after reset and on request (fence.i / context flush).

---
 rtl/branch_target_buffer_pkg.sv | 20 ++
 rtl/branch_target_buffer_if.sv | 43 ++++
 rtl/branch_target_buffer_entry_ram.sv | 45 ++++
 rtl/branch_target_buffer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: FSM state encodings plus PC index/tag slicing macros,
// also used by the ID-stage direction predictor.
`ifndef BRANCH_TARGET_BUFFER_PKG_SV
`define BRANCH_TARGET_BUFFER_PKG_SV

`define BTB_PC_IDX(pc, ib) pc[(ib)+1:2]
`define BTB_PC_TAG(pc, ib) pc[31:(ib)+2]

package branch_target_buffer_pkg;

    typedef enum logic {
        BTB_ST_SWEEP = 1'b0,
        BTB_ST_IDLE  = 1'b1
    } btb_state_e;

    localparam int BTB_PC_W = 32;

endpackage

`endif

// File: rtl/branch_target_buffer_if.sv
// Fetch/MEM-side bundle of the branch target buffer.
// Optional BTB_STATS_EN adds the statistics counters to the bundle.
interface branch_target_buffer_if;
    import branch_target_buffer_pkg::*;

    logic [BTB_PC_W-1:0] lookup_pc;
    logic                lookup_valid;
    logic                hit;
    logic [BTB_PC_W-1:0] hit_target;
    logic                update_valid;
    logic [BTB_PC_W-1:0] update_pc;
    logic [BTB_PC_W-1:0] update_target;
    logic                update_taken;
    logic                invalidate_req;
    logic                busy;
`ifdef BTB_STATS_EN
    logic [31:0]         stat_lookups;
    logic [31:0]         stat_hits;
    logic [31:0]         stat_updates;

    modport master (
        output lookup_pc, lookup_valid, update_valid, update_pc, update_target,
               update_taken, invalidate_req,
        input  hit, hit_target, busy, stat_lookups, stat_hits, stat_updates
    );
    modport slave (
        input  lookup_pc, lookup_valid, update_valid, update_pc, update_target,
               update_taken, invalidate_req,
        output hit, hit_target, busy, stat_lookups, stat_hits, stat_updates
    );
`else
    modport master (
        output lookup_pc, lookup_valid, update_valid, update_pc, update_target,
               update_taken, invalidate_req,
        input  hit, hit_target, busy
    );
    modport slave (
        input  lookup_pc, lookup_valid, update_valid, update_pc, update_target,
               update_taken, invalidate_req,
        output hit, hit_target, busy
    );
`endif
endinterface

// File: rtl/branch_target_buffer_entry_ram.sv
// BTB entry storage {valid, tag, target}: combinational lookup read, a valid/tag
// probe for update matching, one write port, and a sweep clear of valid.
module btb_entry_ram #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 26
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_target,
    input  logic [IDX_BITS-1:0] probe_idx,
    output logic                probe_valid,
    output logic [TAG_BITS-1:0] probe_tag,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_valid,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_target,
    input  logic                clr_en,
    input  logic [IDX_BITS-1:0] clr_idx
);
    localparam int ENTRIES = 1 << IDX_BITS;

    // Deliberately unreset so the arrays map onto RAM; the sweep owns valid.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx]  <= wr_valid;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

    assign rd_valid    = valid_q[rd_idx];
    assign rd_tag      = tag_q[rd_idx];
    assign rd_target   = target_q[rd_idx];
    assign probe_valid = valid_q[probe_idx];
    assign probe_tag   = tag_q[probe_idx];
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the IF stage with a valid-clear sweep.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int TAG_BITS = 30 - IDX_BITS;

    btb_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    logic                busy;
    logic                upd_accept;
    logic                upd_match;
    logic                rd_valid, probe_valid;
    logic [TAG_BITS-1:0] rd_tag, probe_tag;
    logic [31:0]         rd_target;
    logic                hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BTB_ST_SWEEP;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            BTB_ST_SWEEP: begin
                if (bus.invalidate_req) begin
                    sweep_idx_d = '0;
                end else if (&sweep_idx_q) begin
                    state_d     = BTB_ST_IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                end
            end
            BTB_ST_IDLE: begin
                if (bus.invalidate_req) begin
                    state_d     = BTB_ST_SWEEP;
                    sweep_idx_d = '0;
                end
            end
            default: begin
                state_d     = BTB_ST_SWEEP;
                sweep_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == BTB_ST_SWEEP);
        // An invalidate in the same cycle wins over the update.
        upd_accept = (state_q == BTB_ST_IDLE) && bus.update_valid && !bus.invalidate_req;
    end

    assign upd_match = probe_valid && (probe_tag == `BTB_PC_TAG(bus.update_pc, IDX_BITS));

    btb_entry_ram #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_ram (
        .clk         (clk),
        .rd_idx      (`BTB_PC_IDX(bus.lookup_pc, IDX_BITS)),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_target   (rd_target),
        .probe_idx   (`BTB_PC_IDX(bus.update_pc, IDX_BITS)),
        .probe_valid (probe_valid),
        .probe_tag   (probe_tag),
        .wr_en       (upd_accept && (bus.update_taken || upd_match)),
        .wr_idx      (`BTB_PC_IDX(bus.update_pc, IDX_BITS)),
        .wr_valid    (bus.update_taken),
        .wr_tag      (`BTB_PC_TAG(bus.update_pc, IDX_BITS)),
        .wr_target   (bus.update_target),
        .clr_en      (busy),
        .clr_idx     (sweep_idx_q)
    );

    assign hit = bus.lookup_valid && !busy && rd_valid &&
                 (rd_tag == `BTB_PC_TAG(bus.lookup_pc, IDX_BITS));

    assign bus.hit        = hit;
    assign bus.hit_target = hit ? rd_target : 32'h0;
    assign bus.busy       = busy;

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_q, stat_hits_q, stat_updates_q;
    logic        lookup_counted;

    assign lookup_counted = bus.lookup_valid && !busy;

    // Saturating counters; an invalidate leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
            stat_updates_q <= '0;
        end else begin
            if (lookup_counted && !(&stat_lookups_q)) stat_lookups_q <= stat_lookups_q + 32'd1;
            if (hit && !(&stat_hits_q))               stat_hits_q    <= stat_hits_q + 32'd1;
            if (upd_accept && !(&stat_updates_q))     stat_updates_q <= stat_updates_q + 32'd1;
        end
    end

    assign bus.stat_lookups = stat_lookups_q;
    assign bus.stat_hits    = stat_hits_q;
    assign bus.stat_updates = stat_updates_q;
`endif
endmodule
